// File: rtl/sqrt_result_buffer.sv
// Result FIFO behind the stall-free pipelined integer square root.
// Issues source credit covering both buffered and still-in-flight results.
module sqrt_result_buffer #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned DW    = 16,
   parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             src_vld,
   output logic             src_ready,
   input  logic             res_vld,
   input  logic [16:0]      res_y,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [DW-1:0]    m_data,
   output logic [CNT_W-1:0] level,
   output logic [CNT_W-1:0] inflight,
   output logic             ovf,
   output logic             err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] LevelFull = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CntMax    = '1;

   logic [DW-1:0]    mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] level_q, level_d;
   logic [CNT_W-1:0] inflight_q, inflight_d;
   logic             ovf_q, err_q;
   logic             push, pop, bad_res;

   always_comb begin
      pop     = (level_q != '0) & m_ready;
      // A full FIFO still takes a result when the head leaves in the same cycle.
      push    = res_vld & ((level_q != LevelFull) | pop);
      bad_res = res_vld & ((inflight_q == '0) | res_y[16]);

      level_d = level_q;
      unique case ({push, pop})
         2'b10:   level_d = level_q + CNT_W'(1);
         2'b01:   level_d = level_q - CNT_W'(1);
         default: level_d = level_q;
      endcase

      inflight_d = inflight_q;
      if (src_vld && !res_vld && inflight_q != CntMax) begin
         inflight_d = inflight_q + CNT_W'(1);
      end else if (!src_vld && res_vld && inflight_q != '0) begin
         inflight_d = inflight_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         inflight_q <= '0;
         ovf_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         level_q    <= level_d;
         inflight_q <= inflight_d;
         if (res_vld && !push) ovf_q <= 1'b1;
         if (bad_res)          err_q <= 1'b1;
      end
   end

   // Storage needs no reset; the output mux hides stale entries.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= res_y[DW-1:0];
   end

   always_comb begin
      src_ready = ({1'b0, level_q} + {1'b0, inflight_q}) < (CNT_W + 1)'(DEPTH);
      m_valid   = (level_q != '0);
      m_data    = m_valid ? mem_q[rd_ptr_q] : '0;
      level     = level_q;
      inflight  = inflight_q;
      ovf       = ovf_q;
      err       = err_q;
   end

endmodule

// File: tb/tb_sqrt_result_buffer.sv
// Directed bench for sqrt_result_buffer: a result scoreboard plus a small
// occupancy/credit/flag model checked every cycle.
module tb_sqrt_result_buffer;

   localparam int DEPTH = 8;
   localparam int DW    = 16;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             src_vld, src_ready, res_vld, m_valid, m_ready, ovf, err;
   logic [16:0]      res_y;
   logic [DW-1:0]    m_data;
   logic [CNT_W-1:0] level, inflight;

   int n_chk  = 0;
   int n_fail = 0;
   int n_pop  = 0;

   logic [15:0] exp_q[$];
   int mdl_lvl, mdl_inf;
   bit mdl_ovf, mdl_err;

   always #5 clk = ~clk;

   sqrt_result_buffer #(.DEPTH(DEPTH), .DW(DW), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .src_vld  (src_vld),
      .src_ready(src_ready),
      .res_vld  (res_vld),
      .res_y    (res_y),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data),
      .level    (level),
      .inflight (inflight),
      .ovf      (ovf),
      .err      (err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mdl_lvl = 0;
      mdl_inf = 0;
      mdl_ovf = 1'b0;
      mdl_err = 1'b0;
      exp_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_m_valid"},  32'(m_valid),  32'(0));
      check({tag, "_m_data"},   32'(m_data),   32'(0));
      check({tag, "_level"},    32'(level),    32'(0));
      check({tag, "_inflight"}, 32'(inflight), 32'(0));
      check({tag, "_ovf"},      32'(ovf),      32'(0));
      check({tag, "_err"},      32'(err),      32'(0));
   endtask

   // One clock: drive inputs, score any pop, advance the model, check state after the edge.
   task automatic cycle(input logic sv, input logic rv, input logic [16:0] y, input logic rdy);
      logic        acc, pop;
      logic [15:0] e;
      src_vld = sv;
      res_vld = rv;
      res_y   = y;
      m_ready = rdy;
      check("m_valid", 32'(m_valid), 32'(mdl_lvl != 0));
      pop = rdy && (mdl_lvl > 0);
      if (pop) begin
         n_pop++;
         n_chk++;
         assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL sb_underflow: observed pop with m_data 0x%0h expected no pop", m_data);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("m_data", 32'(m_data), 32'(e));
         end
      end
      acc = rv && ((mdl_lvl < DEPTH) || pop);
      if (acc) exp_q.push_back(y[15:0]);
      if (rv && !acc) mdl_ovf = 1'b1;
      if (rv && (mdl_inf == 0 || y[16])) mdl_err = 1'b1;
      mdl_lvl += int'(acc) - int'(pop);
      if (sv && !rv && mdl_inf < 15) mdl_inf++;
      else if (!sv && rv && mdl_inf > 0) mdl_inf--;
      @(posedge clk);
      #1;
      check("level",     32'(level),     32'(mdl_lvl));
      check("inflight",  32'(inflight),  32'(mdl_inf));
      check("src_ready", 32'(src_ready), 32'((mdl_lvl + mdl_inf) < DEPTH));
      check("ovf",       32'(ovf),       32'(mdl_ovf));
      check("err",       32'(err),       32'(mdl_err));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: observed simulation still running expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit pipe [16];
      int issued, next_y, pops0;
      bit tog, sv, rv;

      src_vld = 1'b0;
      res_vld = 1'b0;
      res_y   = '0;
      m_ready = 1'b0;
      rst_n   = 1'b0;
      model_reset();

      // Reset state
      #12;
      check_reset_outputs("rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("rst_src_ready", 32'(src_ready), 32'(1));

      // Single result, one-cycle latency
      cycle(1'b1, 1'b0, 17'd0, 1'b1);
      cycle(1'b0, 1'b1, 17'd255, 1'b1);
      check("single_valid", 32'(m_valid), 32'(1));
      check("single_data",  32'(m_data),  32'(255));
      cycle(1'b0, 1'b0, 17'd0, 1'b1);

      // Credit exhaustion and fill
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 17'd0, 1'b0);
      check("credit_out", 32'(src_ready), 32'(0));
      for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 17'(i), 1'b0);
      cycle(1'b0, 1'b0, 17'd0, 1'b0);
      check("full_level", 32'(level), 32'(8));
      check("full_credit", 32'(src_ready), 32'(0));

      // Full with simultaneous pop, then full without pop
      cycle(1'b1, 1'b0, 17'd0, 1'b0);
      cycle(1'b0, 1'b1, 17'd100, 1'b1);
      check("simul_ovf", 32'(ovf), 32'(0));
      cycle(1'b1, 1'b0, 17'd0, 1'b0);
      cycle(1'b0, 1'b1, 17'd101, 1'b0);
      check("drop_ovf", 32'(ovf), 32'(1));
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 17'd0, 1'b1);

      // Reset mid-operation
      cycle(1'b1, 1'b0, 17'd0, 1'b0);
      cycle(1'b1, 1'b1, 17'd7, 1'b0);
      #2;
      src_vld = 1'b0;
      res_vld = 1'b0;
      res_y   = '0;
      rst_n   = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      #1;
      check("midrst_src_ready", 32'(src_ready), 32'(1));

      // Credit-paced stream through a 16-cycle latency model, consumer toggling
      for (int i = 0; i < 16; i++) pipe[i] = 1'b0;
      issued = 0;
      next_y = 0;
      tog    = 1'b1;
      pops0  = n_pop;
      for (int c = 0; c < 3000; c++) begin
         if (issued == 100 && mdl_inf == 0 && mdl_lvl == 0) break;
         sv = ((mdl_lvl + mdl_inf) < DEPTH) && (issued < 100);
         rv = pipe[15];
         for (int k = 15; k > 0; k--) pipe[k] = pipe[k-1];
         pipe[0] = sv;
         cycle(sv, rv, rv ? 17'(next_y) : 17'd0, tog);
         if (sv) issued++;
         if (rv) next_y++;
         tog = ~tog;
      end
      check("stream_results", 32'(next_y), 32'(100));
      check("stream_pops",    32'(n_pop - pops0), 32'(100));
      check("stream_level",   32'(level), 32'(0));
      check("stream_ovf",     32'(ovf), 32'(0));

      // Error cases
      cycle(1'b0, 1'b1, 17'd5, 1'b0);
      check("orphan_err",      32'(err),      32'(1));
      check("orphan_inflight", 32'(inflight), 32'(0));
      cycle(1'b0, 1'b0, 17'd0, 1'b1);
      cycle(1'b1, 1'b0, 17'd0, 1'b0);
      cycle(1'b0, 1'b1, 17'h10000, 1'b0);
      check("trunc_valid", 32'(m_valid), 32'(1));
      check("trunc_data",  32'(m_data),  32'(0));
      cycle(1'b0, 1'b0, 17'd0, 1'b1);
      check("final_level", 32'(level), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
